hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and sequencing controller for the five-stage RV32I core. Generates operand-forwarding selects for the Execute stage, stall/flush enables for every pipeline register, and sequences data-memory wait states with a bounded-timeout FSM. It sits beside the datapath and steers the ALU operand muxes and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, so a stalled load never reaches the writeback result mux early or twice.

## Interface
- MEM_TIMEOUT, 255: maximum WAIT-state cycles before declaring a memory error (1..2^TO_W-1).
- TO_W, 8: width of the timeout counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers of the Decode instruction.
- Rs1E, Rs2E, RdE  in  5 each  sources and destination of the Execute instruction.
- RdM, RdW  in  5 each  destinations in Memory and Writeback.
- RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
- ResultSrcE  in  2  result select of the Execute instruction; 00 ALU, 01 memory (load), 10 PC+4.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- MemReqM  in  1  Memory-stage instruction is a load or store.
- MemReady  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2 each  operand select; 00 register file, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1 each  clear IF/ID, ID/EX and MEM/WB to a bubble.
- MemErr  out  1  sticky memory-timeout error.
- StallCnt, FlushCnt  out  32 each  performance counters (see Configuration).

## Operation
- Forwarding (ForwardAE, with Rs2E for ForwardBE):
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise 00. The Memory stage has priority.
- lwStall = (ResultSrcE==01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D) and not PCSrcE. It is suppressed on a taken branch because the Decode instruction is being flushed.
- FSM states:
  - RUN to WAIT when MemReqM and not MemReady; counter loads 1.
  - WAIT to RUN when MemReady; counter clears.
  - WAIT with not MemReady: to ERR if counter==MEM_TIMEOUT, else counter+1.
  - ERR is terminal until reset.
- memStall = (RUN and MemReqM and not MemReady) or (WAIT and not MemReady) or ERR.
- Stall and flush equations:
  - StallF = StallD = lwStall or memStall.
  - StallE = StallM = memStall.
  - FlushW = memStall, which prevents double writeback of the frozen instruction.
  - FlushD = PCSrcE and not memStall.
  - FlushE = (lwStall or PCSrcE) and not memStall.
  - memStall dominates everything: the front end is frozen and no flush is applied.
- MemErr = 1 exactly in ERR.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the registered state; no added latency.
- Reset: state RUN, counter 0, MemErr 0, StallCnt and FlushCnt 0.
  - Reset outputs while all inputs are idle: Forward*=00, every Stall*/Flush*=0.
- Reset asserted mid-WAIT or in ERR returns to RUN on the next edge.
- Single-cycle memory (MemReady high together with MemReqM): no stall, FSM stays in RUN.
- A MemReady arriving on the cycle the counter equals MEM_TIMEOUT completes the access; it does not raise an error.
- Worst-case stall before ERR: MEM_TIMEOUT+1 cycles.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments every cycle StallF=1.
  - FlushCnt increments every cycle FlushE=1 caused by PCSrcE.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: StallCnt and FlushCnt are tied to 0 and no counter flops exist.

## Structure
- Package rv32i_pkg holds:
  - ResultSrc encodings RES_ALU/RES_MEM/RES_PC4.
  - Forward encodings FWD_RF/FWD_WB/FWD_MEM.
  - The hazard FSM state enum (RUN, WAIT, ERR).
- One sub-module, hazard_perf_cnt: a saturating 32-bit counter instantiated twice under HAZARD_PERF_CNT_EN.

## Test plan
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; set RegWriteM=0 -> ForwardAE=01; set Rs1E=0 -> 00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle; same stimulus with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
- MemReqM=1, MemReady low 3 cycles then high -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, FSM returns to RUN, MemErr=0.
- MEM_TIMEOUT=4, MemReqM=1, MemReady held 0 -> ERR entered on cycle 5 after the request; MemErr=1 held until reset, which clears it on the next edge.
- PCSrcE=1 during memStall -> FlushD=FlushE=0; PCSrcE=1 alone -> FlushD=FlushE=1.
- With HAZARD_PERF_CNT_EN defined: 10 lwStall cycles plus 3 branch flushes -> StallCnt=10, FlushCnt=3. Without the macro: both read 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared encodings and hazard FSM state for the RV32I core
package rv32i_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } hz_state_t;

    // Memory stage wins over Writeback: it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return FWD_MEM;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - datapath <-> hazard unit signal bundle
interface hazard_unit_if;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemReqM, MemReady;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       MemErr;
    logic [31:0] StallCnt, FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MemReqM, MemReady,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MemReqM, MemReady,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating 32-bit event counter
// ENABLE=0 (HAZARD_PERF_CNT_EN undefined in the top) leaves a constant zero and no flops.
module hazard_perf_cnt #(
    parameter bit ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);
    generate
        if (ENABLE) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset)
                    count <= '0;
                else if (en && count != 32'hFFFF_FFFF)
                    count <= count + 32'd1;
            end
        end else begin : g_tie
            wire unused = &{1'b0, clk, reset, en};
            assign count = '0;
        end
    endgenerate
endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush and memory wait-state control
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_unit
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    hz_state_t       state, state_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic            lw_stall, mem_stall;

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

    // A taken branch flushes Decode anyway, so a load-use stall would be wasted.
    assign lw_stall = (hz.ResultSrcE == RES_MEM) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !hz.PCSrcE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mem_stall = 1'b0;
        case (state)
            RUN: begin
                if (hz.MemReqM && !hz.MemReady) begin
                    mem_stall = 1'b1;
                    state_n   = WAIT;
                    cnt_n     = TO_W'(1);
                end
            end
            WAIT: begin
                if (hz.MemReady) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (cnt == TO_W'(MEM_TIMEOUT))
                        state_n = ERR;
                    else
                        cnt_n = cnt + TO_W'(1);
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // memStall freezes the whole front end and overrides every flush.
    assign hz.StallF = lw_stall || mem_stall;
    assign hz.StallD = lw_stall || mem_stall;
    assign hz.StallE = mem_stall;
    assign hz.StallM = mem_stall;
    assign hz.FlushW = mem_stall;
    assign hz.FlushD = hz.PCSrcE && !mem_stall;
    assign hz.FlushE = (lw_stall || hz.PCSrcE) && !mem_stall;
    assign hz.MemErr = (state == ERR);

    hazard_perf_cnt #(.ENABLE(PERF_EN)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (hz.StallF),
        .count (hz.StallCnt)
    );

    hazard_perf_cnt #(.ENABLE(PERF_EN)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (hz.PCSrcE && !mem_stall),
        .count (hz.FlushCnt)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;
    import rv32i_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if hz();

    hazard_unit #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    int     n_vec = 0;
    int     n_bad = 0;
    int     m_run;
    bit     m_err;
    longint m_scnt, m_fcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic idle();
        {hz.Rs1D, hz.Rs2D, hz.Rs1E, hz.Rs2E, hz.RdE, hz.RdM, hz.RdW} = '0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE = RES_ALU;
        hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReady = 0; reset = 0;
    endtask

    // Called at a negedge with inputs set; checks all outputs, then advances the model.
    task automatic cycle();
        bit lw, ms, stf;
        #1;
        lw  = (hz.ResultSrcE == 2'b01) && hz.RdE != 0 &&
              (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D) && !hz.PCSrcE;
        ms  = m_err || ((m_run > 0 || hz.MemReqM) && !hz.MemReady);
        stf = lw || ms;
        check("fwdA",   hz.ForwardAE, ref_fwd(hz.Rs1E));
        check("fwdB",   hz.ForwardBE, ref_fwd(hz.Rs2E));
        check("stallF", hz.StallF, stf);
        check("stallD", hz.StallD, stf);
        check("stallE", hz.StallE, ms);
        check("stallM", hz.StallM, ms);
        check("flushD", hz.FlushD, hz.PCSrcE && !ms);
        check("flushE", hz.FlushE, (lw || hz.PCSrcE) && !ms);
        check("flushW", hz.FlushW, ms);
        check("memerr", hz.MemErr, m_err);
`ifdef HAZARD_PERF_CNT_EN
        check("scnt", hz.StallCnt, sat32(m_scnt));
        check("fcnt", hz.FlushCnt, sat32(m_fcnt));
`else
        check("scnt", hz.StallCnt, 32'd0);
        check("fcnt", hz.FlushCnt, 32'd0);
`endif
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            m_scnt += stf;
            m_fcnt += (hz.PCSrcE && !ms);
            if (!m_err) begin
                if (ms) begin
                    m_run++;
                    if (m_run > TO) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        m_run = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        cycle();

        // Forwarding priority
        hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5;
        #1 check("fwd_mem_pri", hz.ForwardAE, 2'b10);
        cycle();
        hz.RegWriteM = 0;
        #1 check("fwd_wb", hz.ForwardAE, 2'b01);
        cycle();
        hz.Rs1E = 0;
        #1 check("fwd_x0", hz.ForwardAE, 2'b00);
        cycle();

        // Load-use stall, then suppressed by a taken branch
        idle(); hz.ResultSrcE = RES_MEM; hz.RdE = 7; hz.Rs2D = 7;
        #1 check("lw_stallF", hz.StallF, 1'b1);
        check("lw_flushE", hz.FlushE, 1'b1);
        check("lw_flushD", hz.FlushD, 1'b0);
        cycle();
        hz.PCSrcE = 1;
        #1 check("br_stallF", hz.StallF, 1'b0);
        check("br_flushD", hz.FlushD, 1'b1);
        cycle();

        // Three memory wait cycles, then completion
        idle(); hz.MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("wait_stallM", hz.StallM, 1'b1);
            check("wait_flushW", hz.FlushW, 1'b1);
            cycle();
        end
        hz.MemReady = 1;
        #1 check("done_stallM", hz.StallM, 1'b0);
        cycle();
        idle();
        #1 check("done_memerr", hz.MemErr, 1'b0);
        cycle();

        // Branch during memStall is held off; alone it flushes
        hz.MemReqM = 1; hz.PCSrcE = 1;
        #1 check("ms_flushE", hz.FlushE, 1'b0);
        cycle();
        hz.MemReqM = 0; hz.MemReady = 1;
        #1 check("br_flushE", hz.FlushE, 1'b1);
        cycle();

        // Performance counters: 10 load-use stalls plus 3 branch flushes
        idle(); reset = 1; cycle(); reset = 0;
        hz.ResultSrcE = RES_MEM; hz.RdE = 9; hz.Rs1D = 9; hz.MemReady = 1;
        repeat (10) cycle();
        hz.ResultSrcE = RES_ALU; hz.PCSrcE = 1;
        repeat (3) cycle();
        idle();
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall10", hz.StallCnt, 32'd10);
        check("perf_flush3",  hz.FlushCnt, 32'd3);
`else
        check("perf_stall0", hz.StallCnt, 32'd0);
        check("perf_flush0", hz.FlushCnt, 32'd0);
`endif
        cycle();

        // Timeout: ERR after TO+1 stalled cycles, sticky until reset
        hz.MemReqM = 1; hz.MemReady = 0;
        for (int i = 0; i <= TO; i++) begin
            #1 check("pre_err", hz.MemErr, 1'b0);
            cycle();
        end
        #1 check("err_set", hz.MemErr, 1'b1);
        cycle();
        hz.MemReady = 1; hz.MemReqM = 0;
        #1 check("err_sticky", hz.MemErr, 1'b1);
        check("err_stallF", hz.StallF, 1'b1);
        cycle();
        reset = 1; cycle(); reset = 0;
        #1 check("err_cleared", hz.MemErr, 1'b0);
        cycle();

        // Boundary: ready arrives exactly when the counter hits the limit
        hz.MemReqM = 1; hz.MemReady = 0;
        repeat (TO) cycle();
        hz.MemReady = 1;
        cycle();
        hz.MemReqM = 0;
        #1 check("edge_no_err", hz.MemErr, 1'b0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
            hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
            hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
            hz.RdW  = 5'($urandom_range(0, 3));
            hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
            hz.ResultSrcE = 2'($urandom_range(0, 2));
            hz.PCSrcE = ($urandom_range(0, 3) == 0);
            hz.MemReqM = 1'($urandom);
            hz.MemReady = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
